// File: rtl/multibyte_add_controller.sv
// rtl/multibyte_add_controller.sv - sequences a W-bit addition through an external 8-bit adder, one byte per cycle
module multibyte_add_controller #(
  parameter int NBYTES = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [8*NBYTES-1:0]   A,
  input  logic [8*NBYTES-1:0]   B,
  input  logic                  CIN,
  output logic [7:0]            ADD_X,
  output logic [7:0]            ADD_Y,
  output logic                  ADD_CIN,
  input  logic [7:0]            ADD_S,
  input  logic                  ADD_COUT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [8*NBYTES-1:0]   SUM,
  output logic                  COUT,
  output logic                  OVF
);

  localparam int W = 8 * NBYTES;
  localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [2:0]     idx_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic           cin_q;
  logic           carry_q;
  logic [W-1:0]   shadow_q;
  logic [W-1:0]   shadow_d;
  logic [5:0]     bit_ofs;
  logic           last_byte;

  assign bit_ofs   = {idx_q, 3'b000};
  assign last_byte = (idx_q == LAST_IDX);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: START is only honoured outside RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = START ? RUN : IDLE;
      RUN:     state_d = last_byte ? FIN : RUN;
      FIN:     state_d = START ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Adder drive and status outputs; the adder sees zeros whenever no byte is in flight
  always_comb begin
    ADD_X   = 8'h00;
    ADD_Y   = 8'h00;
    ADD_CIN = 1'b0;
    BUSY    = 1'b0;
    DONE    = 1'b0;
    case (state_q)
      RUN: begin
        ADD_X   = a_q[bit_ofs +: 8];
        ADD_Y   = b_q[bit_ofs +: 8];
        ADD_CIN = (idx_q == 3'd0) ? cin_q : carry_q;
        BUSY    = 1'b1;
      end
      FIN: begin
        DONE = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Shadow result with the current adder byte merged in at the active position
  always_comb begin
    shadow_d = shadow_q;
    shadow_d[bit_ofs +: 8] = ADD_S;
  end

  // Operand capture, per-byte accumulation and final result commit
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx_q    <= 3'd0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      shadow_q <= '0;
      SUM      <= '0;
      COUT     <= 1'b0;
      OVF      <= 1'b0;
    end else if (state_q == RUN) begin
      shadow_q <= shadow_d;
      carry_q  <= ADD_COUT;
      if (last_byte) begin
        idx_q <= 3'd0;
        SUM   <= shadow_d;
        COUT  <= ADD_COUT;
        OVF   <= (a_q[W-1] == b_q[W-1]) && (ADD_S[7] != a_q[W-1]);
      end else begin
        idx_q <= idx_q + 3'd1;
      end
    end else if (START) begin
      a_q   <= A;
      b_q   <= B;
      cin_q <= CIN;
      idx_q <= 3'd0;
    end
  end

endmodule
